alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Four-register micro-sequencer driving an external 8-bit ALU: IDLE/DECODE/EXECUTE/WRITEBACK.
// Optional carry/borrow output carry_flag is built only when ALU_SEQ_CARRY_EN is defined.
module alu_sequencer #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       instr,
   input  logic              instr_valid,
   output logic              instr_ready,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_sel,
   input  logic [DATA_W-1:0] alu_out,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              zero_flag,
   input  logic [1:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
`ifdef ALU_SEQ_CARRY_EN
   ,
   output logic              carry_flag
`endif
);

   typedef enum logic [1:0] {
      StIdle,
      StDecode,
      StExecute,
      StWriteback
   } state_e;

   state_e state_q, state_d;

   logic [15:0]       instr_q;
   logic [DATA_W-1:0] regs_q [4];
   logic [DATA_W-1:0] alu_a_q, alu_b_q, exe_q, result_q;
   logic [2:0]        alu_sel_q;
   logic              done_q, zero_q;
   logic              accept;

   // Fields of the accepted instruction
   logic              is_imm;
   logic [2:0]        op_sel;
   logic [1:0]        rd, ra, rb;
   logic [DATA_W-1:0] imm, wb_val;

   always_comb begin
      is_imm = instr_q[15];
      op_sel = instr_q[14:12];
      rd     = is_imm ? instr_q[9:8] : instr_q[11:10];
      ra     = instr_q[9:8];
      rb     = instr_q[7:6];
      imm    = instr_q[7:0];
      wb_val = is_imm ? imm : exe_q;
   end

   assign instr_ready = (state_q == StIdle);
   assign accept      = instr_valid && instr_ready;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = instr[15] ? StWriteback : StDecode;
            end
         end
         StDecode:    state_d = StExecute;
         StExecute:   state_d = StWriteback;
         StWriteback: state_d = StIdle;
         default:     state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef ALU_SEQ_CARRY_EN
   logic              carry_exe_q, carry_q;
   logic [DATA_W:0]   sum_ext;

   // Carry is derived from the latched operands, independent of the external ALU
   assign sum_ext = {1'b0, alu_a_q} + {1'b0, alu_b_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_exe_q <= 1'b0;
         carry_q     <= 1'b0;
      end else begin
         if (state_q == StExecute) begin
            unique case (alu_sel_q)
               3'b100:  carry_exe_q <= sum_ext[DATA_W];
               3'b101:  carry_exe_q <= (alu_a_q < alu_b_q);
               default: carry_exe_q <= 1'b0;
            endcase
         end
         if (state_q == StWriteback && !is_imm) begin
            carry_q <= carry_exe_q;
         end
      end
   end

   assign carry_flag = carry_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q   <= '0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_sel_q <= '0;
         exe_q     <= '0;
         result_q  <= '0;
         zero_q    <= 1'b1;
         done_q    <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  instr_q <= instr;
               end
            end
            StDecode: begin
               alu_a_q   <= regs_q[ra];
               alu_b_q   <= regs_q[rb];
               alu_sel_q <= op_sel;
            end
            StExecute: begin
               exe_q <= alu_out;
            end
            StWriteback: begin
               regs_q[rd] <= wb_val;
               result_q   <= wb_val;
               zero_q     <= (wb_val == '0);
               done_q     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_sel   = alu_sel_q;
   assign done      = done_q;
   assign result    = result_q;
   assign zero_flag = zero_q;
   // Old register value stays visible until the writeback edge
   assign dbg_data  = regs_q[dbg_addr];

endmodule
